// File: rtl/instruction_fetch_stage_if.sv
// Bus between the instruction fetch stage and its controller/decode neighbours.
// master drives loads, run control and hazard requests; slave is the fetch stage itself.
interface instruction_fetch_stage_if #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned MEM_DEPTH = 256
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic             i_load_en;
    logic [AW-1:0]    i_load_addr;
    logic [NBITS-1:0] i_load_data;
    logic             i_run;
    logic             i_step_mode;
    logic             i_step;
    logic             i_stall;
    logic             i_redirect_en;
    logic [NBITS-1:0] i_redirect_pc;
    logic [NBITS-1:0] o_pc;
    logic [NBITS-1:0] o_instruction;
    logic             o_valid;
    logic             o_halted;
    logic [1:0]       o_state;

    modport master (
        output i_load_en, i_load_addr, i_load_data, i_run, i_step_mode, i_step,
               i_stall, i_redirect_en, i_redirect_pc,
        input  o_pc, o_instruction, o_valid, o_halted, o_state
    );

    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_run, i_step_mode, i_step,
               i_stall, i_redirect_en, i_redirect_pc,
        output o_pc, o_instruction, o_valid, o_halted, o_state
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC, loadable instruction memory, IF/ID register and run-control FSM.
// Define IF_STEP_MODE_EN to enable the single-step (STEP) state.
module instruction_fetch_stage #(
    parameter int unsigned      NBITS      = 32,
    parameter int unsigned      MEM_DEPTH  = 256,
    parameter logic [NBITS-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    instruction_fetch_stage_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10,
        StHalt = 2'b11
    } state_e;

    state_e           r_state;
    logic [NBITS-1:0] r_mem [MEM_DEPTH];
    logic [NBITS-1:0] r_pc;
    logic [NBITS-1:0] r_ifid_pc;
    logic [NBITS-1:0] r_ifid_instr;
    logic             r_ifid_valid;
    logic             r_halted;

    logic [NBITS-1:0] w_fetch;
    logic             w_active;
    state_e           w_run_target;

    assign w_fetch = r_mem[r_pc[AW+1:2]];

`ifdef IF_STEP_MODE_EN
    // In STEP a redirect still lands without a step pulse.
    assign w_active = (r_state == StRun) ||
                      ((r_state == StStep) && (bus.i_step || bus.i_redirect_en));
    assign w_run_target = bus.i_step_mode ? StStep : StRun;
`else
    logic w_unused_step;
    assign w_unused_step = bus.i_step_mode ^ bus.i_step;
    assign w_active      = (r_state == StRun);
    assign w_run_target  = StRun;
`endif

    // Program memory is deliberately not reset so a program survives i_rst.
    always_ff @(posedge i_clk) begin
        if ((r_state == StIdle) && bus.i_load_en) begin
            r_mem[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pc         <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_pc         <= '0;
                    r_ifid_instr <= '0;
                    r_ifid_valid <= 1'b0;
                    if (bus.i_run) begin
                        r_state <= w_run_target;
                    end
                end
                StRun, StStep: begin
                    if (w_active) begin
                        if (bus.i_redirect_en) begin
                            r_pc         <= bus.i_redirect_pc;
                            r_ifid_instr <= '0;
                            r_ifid_valid <= 1'b0;
                        end else if (!bus.i_stall) begin
                            r_ifid_pc    <= r_pc;
                            r_ifid_instr <= w_fetch;
                            r_ifid_valid <= 1'b1;
                            if (w_fetch == HALT_INSTR) begin
                                r_state  <= StHalt;
                                r_halted <= 1'b1;
                            end else begin
                                r_pc <= r_pc + NBITS'(4);
                            end
                        end
                    end
                end
                StHalt: begin
                    r_ifid_instr <= '0;
                    r_ifid_valid <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_pc          = r_ifid_pc;
    assign bus.o_instruction = r_ifid_instr;
    assign bus.o_valid       = r_ifid_valid;
    assign bus.o_halted      = r_halted;
    assign bus.o_state       = r_state;
endmodule
